// File: rtl/io_bus_decoder.sv
// I/O bus decoder: splits the CPU I/O address into slot select and register offset,
// runs the slot handshake with a timeout, and logs failed accesses as bus errors.
module io_bus_decoder #(
    parameter int unsigned                  DEV_AW    = 3,
    parameter int unsigned                  REG_AW    = 4,
    parameter int unsigned                  DW        = 32,
    parameter logic [(2**DEV_AW)-1:0]       SLOT_MASK = 8'h0F,
    parameter int unsigned                  TIMEOUT   = 16
) (
    input  logic                            Clock,
    input  logic                            Reset,
    input  logic [DEV_AW+REG_AW-1:0]        Addr,
    input  logic                            RdEn,
    input  logic                            WrEn,
    input  logic [DW-1:0]                   WrData,
    output logic [DW-1:0]                   RdData,
    output logic                            Ready,
    output logic                            BusErr,
    output logic [(2**DEV_AW)-1:0]          SlotSel,
    output logic                            SlotWe,
    output logic [REG_AW-1:0]               SlotAddr,
    output logic [DW-1:0]                   SlotWData,
    input  logic [(2**DEV_AW)*DW-1:0]       SlotRData,
    input  logic [(2**DEV_AW)-1:0]          SlotReady,
    input  logic                            ErrClr,
    output logic                            ErrValid,
    output logic [DEV_AW+REG_AW-1:0]        ErrAddr,
    output logic [7:0]                      ErrCount
);

    localparam int unsigned NSLOT        = 2**DEV_AW;
    localparam int unsigned AW           = DEV_AW + REG_AW;
    localparam logic [7:0]  TIMEOUT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       req_addr_q, req_addr_d;
    logic                req_we_q, req_we_d;
    logic                err_q, err_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [DW-1:0]       rd_data_q, rd_data_d;
    logic [NSLOT-1:0]    slot_sel_q, slot_sel_d;
    logic                slot_we_q, slot_we_d;
    logic [REG_AW-1:0]   slot_addr_q, slot_addr_d;
    logic [DW-1:0]       slot_wdata_q, slot_wdata_d;
    logic                err_valid_q, err_valid_d;
    logic [AW-1:0]       err_addr_q, err_addr_d;
    logic [7:0]          err_count_q, err_count_d;

    logic                err_entry;
    logic [AW-1:0]       err_log_addr;
    logic [DEV_AW-1:0]   new_slot;
    logic [DEV_AW-1:0]   cur_slot;
    logic [DW-1:0]       slot_rdata [NSLOT];

    for (genvar s = 0; s < NSLOT; s++) begin : g_rdata
        assign slot_rdata[s] = SlotRData[s*DW +: DW];
    end

    assign new_slot = Addr[AW-1:REG_AW];
    assign cur_slot = req_addr_q[AW-1:REG_AW];

    always_comb begin
        state_d      = state_q;
        req_addr_d   = req_addr_q;
        req_we_d     = req_we_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        rd_data_d    = rd_data_q;
        slot_sel_d   = '0;
        slot_we_d    = 1'b0;
        slot_addr_d  = slot_addr_q;
        slot_wdata_d = slot_wdata_q;
        err_entry    = 1'b0;
        err_log_addr = req_addr_q;

        case (state_q)
            IDLE: begin
                if (RdEn || WrEn) begin
                    req_addr_d   = Addr;
                    req_we_d     = WrEn;
                    err_log_addr = Addr;
                    // Illegal and unmapped requests never strobe a slot.
                    if ((RdEn && WrEn) || !SLOT_MASK[new_slot]) begin
                        err_d     = 1'b1;
                        rd_data_d = '0;
                        err_entry = 1'b1;
                        state_d   = RESP;
                    end else begin
                        err_d        = 1'b0;
                        cnt_d        = '0;
                        slot_sel_d   = {{(NSLOT-1){1'b0}}, 1'b1} << new_slot;
                        slot_we_d    = WrEn;
                        slot_addr_d  = Addr[REG_AW-1:0];
                        slot_wdata_d = WrData;
                        state_d      = ACCESS;
                    end
                end
            end
            ACCESS: begin
                // Ready is checked before the timeout so it wins on the last cycle.
                if (SlotReady[cur_slot]) begin
                    rd_data_d = req_we_q ? '0 : slot_rdata[cur_slot];
                    err_d     = 1'b0;
                    state_d   = RESP;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    rd_data_d = '0;
                    err_d     = 1'b1;
                    err_entry = 1'b1;
                    state_d   = RESP;
                end else begin
                    cnt_d      = cnt_q + 8'd1;
                    slot_sel_d = slot_sel_q;
                    slot_we_d  = slot_we_q;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        err_valid_d = err_valid_q;
        err_addr_d  = err_addr_q;
        err_count_d = err_count_q;

        // A clear that coincides with a new error still records that error.
        if (ErrClr) begin
            if (err_entry) begin
                err_valid_d = 1'b1;
                err_addr_d  = err_log_addr;
                err_count_d = 8'd1;
            end else begin
                err_valid_d = 1'b0;
                err_addr_d  = '0;
                err_count_d = '0;
            end
        end else if (err_entry) begin
            if (!err_valid_q) begin
                err_valid_d = 1'b1;
                err_addr_d  = err_log_addr;
            end
            if (err_count_q != 8'hFF) begin
                err_count_d = err_count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q      <= IDLE;
            req_addr_q   <= '0;
            req_we_q     <= 1'b0;
            err_q        <= 1'b0;
            cnt_q        <= '0;
            rd_data_q    <= '0;
            slot_sel_q   <= '0;
            slot_we_q    <= 1'b0;
            slot_addr_q  <= '0;
            slot_wdata_q <= '0;
            err_valid_q  <= 1'b0;
            err_addr_q   <= '0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            req_addr_q   <= req_addr_d;
            req_we_q     <= req_we_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
            rd_data_q    <= rd_data_d;
            slot_sel_q   <= slot_sel_d;
            slot_we_q    <= slot_we_d;
            slot_addr_q  <= slot_addr_d;
            slot_wdata_q <= slot_wdata_d;
            err_valid_q  <= err_valid_d;
            err_addr_q   <= err_addr_d;
            err_count_q  <= err_count_d;
        end
    end

    assign Ready     = (state_q == RESP);
    assign BusErr    = (state_q == RESP) && err_q;
    assign RdData    = rd_data_q;
    assign SlotSel   = slot_sel_q;
    assign SlotWe    = slot_we_q;
    assign SlotAddr  = slot_addr_q;
    assign SlotWData = slot_wdata_q;
    assign ErrValid  = err_valid_q;
    assign ErrAddr   = err_addr_q;
    assign ErrCount  = err_count_q;

endmodule
